regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised successor to the 2-read/1-write MIPS register file used by the datapath decode stage.
- Generalises data width, depth and read-port count; adds optional hardwired zero register and write-to-read bypass.
- Adds a sequential dump engine: a valid/ready stream of every register (address plus data) for the debug unit, to be sent out over UART.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- NUM_READ, 2: number of asynchronous read ports, minimum 1.
- ZERO_REG, 1: when 1, register 0 reads as 0 and writes to it are discarded.
- BYPASS, 1: when 1, a same-cycle write is forwarded to read and dump outputs.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- w_enable  in  1  write strobe for the write port.
- addres_rd  in  ADDR_W  write address.
- data_rd  in  DATA_W  write data.
- addres_r  in  NUM_READ*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- data_r  out  NUM_READ*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W].
- dump_start  in  1  request a full register dump.
- dump_ready  in  1  consumer accepts the current dump beat.
- dump_valid  out  1  dump beat is valid.
- dump_addr  out  ADDR_W  register index of the current beat.
- dump_data  out  DATA_W  register value of the current beat.
- dump_busy  out  1  dump engine is not IDLE.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - All DEPTH registers clear to 0.
  - Dump FSM goes to IDLE with index 0.
  - dump_valid, dump_busy and dump_done are 0; dump_addr is 0.
  - data_r and dump_data show 0 (array cleared).
- Write:
  - On the rising edge of clk with w_enable=1, mem[addres_rd] <= data_rd.
  - When ZERO_REG=1 and addres_rd=0, the write is dropped.
- Read (combinational, zero latency):
  - data_r[k] = mem[addres_r[k]].
  - When ZERO_REG=1 and the address is 0, the result is 0, irrespective of BYPASS.
  - When BYPASS=1, w_enable=1, addres_rd equals the read address and the write is not dropped, the result is data_rd.
  - When BYPASS=0, a read of the register being written returns the old value until the edge.
  - Any number of ports may read the same address.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: dump_start=1 -> SEND with index=0.
  - SEND: dump_valid=1, dump_addr=index, dump_data = read of index using the same zero/bypass rules as the read ports.
    - On a handshake (dump_valid and dump_ready): if index = DEPTH-1 go to DONE, else index+1.
    - Without a handshake, dump_addr and dump_data are held stable, except that dump_data follows a write to that index (live value).
  - DONE: dump_done=1 for one cycle, then IDLE.
  - dump_start is ignored outside IDLE.
  - Writes and reads continue normally during a dump; there is no stall.
  - Index wrap: the index never exceeds DEPTH-1; the transition to DONE replaces increment-and-wrap.
  - dump_busy=1 in SEND and DONE.
- Reset mid-dump aborts immediately: dump_valid=0, dump_done is not pulsed, state is IDLE.

Decomposition:
- Shared package regfile_pkg holds:
  - dump state encoding localparams: IDLE=2'd0, SEND=2'd1, DONE=2'd2;
  - DEPTH derivation.
- One sub-module: regfile_dump_fsm.
  - Owns state, index, valid/done logic.
  - Drives an address into a dedicated read path of the array.
  - Top level instantiates the array, write logic, NUM_READ read muxes, and the dump read mux.

Test Plan:
- Reset and write-back: write 0xFF010000 to r3 and 0xFF010011 to r1, then set w_enable=0 and addres_r={5'd1,5'd3} -> data_r port0=0xFF010000, port1=0xFF010011. Assert rst -> both read 0.
- Zero register: with ZERO_REG=1, write 0xDEADBEEF to r0 -> r0 reads 0, including during the write cycle with BYPASS=1. With ZERO_REG=0, r0 reads 0xDEADBEEF after the edge.
- Bypass: w_enable=1, addres_rd=7, data_rd=0x12345678, and both ports read r7 in the same cycle -> 0x12345678 when BYPASS=1; the old value 0 when BYPASS=0.
- Dump with backpressure: preload r_i = i*0x11, pulse dump_start, and drive dump_ready=1 every other cycle -> 32 beats with addr 0..31 and data i*0x11 (r0=0). Beats hold while ready=0, dump_done pulses exactly once, and dump_busy drops the cycle after.
- Write during dump: while SEND stalls at index 5 (ready=0), write r5=0xA5A5A5A5 -> dump_data becomes 0xA5A5A5A5 (live with BYPASS=1, else the cycle after the edge). A second dump_start mid-dump is ignored.
- Reset mid-dump plus NUM_READ=4: assert rst at index 10 -> dump_valid=0 at once and no dump_done. Four ports reading r1, r2, r1, r31 return their correct values concurrently.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its dump engine.
package regfile_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_SEND = SEND,
        ST_DONE = DONE
    } dump_state_e;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Sequencer that walks every register index once and presents it as a
// valid/ready stream; the data for each beat is read by the top level.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(depth_of(ADDR_W) - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                // The last beat leads to DONE instead of wrapping the index.
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dump_valid = valid_q;
    assign dump_addr  = idx_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: one write port, NUM_READ combinational read
// ports, optional hardwired zero register, write bypass and a dump stream.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_enable,
    input  logic [ADDR_W-1:0]          addres_rd,
    input  logic [DATA_W-1:0]          data_rd,
    input  logic [NUM_READ*ADDR_W-1:0] addres_r,
    output logic [NUM_READ*DATA_W-1:0] data_r,
    input  logic                       dump_start,
    input  logic                       dump_ready,
    output logic                       dump_valid,
    output logic [ADDR_W-1:0]          dump_addr,
    output logic [DATA_W-1:0]          dump_data,
    output logic                       dump_busy,
    output logic                       dump_done
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_ok;

    assign wr_ok = w_enable && !((ZERO_REG != 0) && (addres_rd == '0));

    // Zero register wins over bypass, so r0 never reflects a dropped write.
    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) begin
            return '0;
        end else if ((BYPASS != 0) && wr_ok && (addres_rd == a)) begin
            return data_rd;
        end
        return mem_q[a];
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[addres_rd] = data_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        data_r = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            data_r[k*DATA_W +: DATA_W] = read_reg(addres_r[k*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        dump_data = read_reg(dump_addr);
    end

    regfile_dump_fsm #(
        .ADDR_W(ADDR_W)
    ) u_dump_fsm (
        .clk       (clk),
        .rst       (rst),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_addr (dump_addr),
        .dump_busy (dump_busy),
        .dump_done (dump_done)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two configurations share one stimulus stream
// and are checked every cycle against an array-based reference model.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_enable = 1'b0;
    logic [4:0]  addres_rd = '0;
    logic [31:0] data_rd = '0;
    logic        dump_start = 1'b0;
    logic        dump_ready = 1'b0;

    // Instance A: 4 read ports, zero register and bypass enabled.
    logic [19:0]  ra = '0;
    logic [127:0] da;
    logic         va, ba, dna;
    logic [4:0]   aa;
    logic [31:0]  dda;

    // Instance B: 2 read ports, no zero register, no bypass.
    logic [9:0]   rb = '0;
    logic [63:0]  db;
    logic         vb, bb, dnb;
    logic [4:0]   ab;
    logic [31:0]  ddb;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int          log_addr [$];
    logic [31:0] log_data [$];

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .w_enable(w_enable), .addres_rd(addres_rd), .data_rd(data_rd),
        .addres_r(ra), .data_r(da), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(va), .dump_addr(aa), .dump_data(dda), .dump_busy(ba), .dump_done(dna)
    );

    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .w_enable(w_enable), .addres_rd(addres_rd), .data_rd(data_rd),
        .addres_r(rb), .data_r(db), .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(vb), .dump_addr(ab), .dump_data(ddb), .dump_busy(bb), .dump_done(dnb)
    );

    // Reference model: plain register arrays plus a dump beat counter.
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic        m_send = 1'b0;
    logic        m_done = 1'b0;
    int          m_idx = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ma[i] <= '0;
                mb[i] <= '0;
            end
            m_send <= 1'b0;
            m_done <= 1'b0;
            m_idx  <= 0;
        end else begin
            if (w_enable) begin
                if (addres_rd != 0) ma[addres_rd] <= data_rd;
                mb[addres_rd] <= data_rd;
            end
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_send) begin
                if (dump_ready) begin
                    if (m_idx == 31) begin
                        m_send <= 1'b0;
                        m_done <= 1'b1;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
            end else if (dump_start) begin
                m_send <= 1'b1;
                m_idx  <= 0;
            end
        end
    end

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (a == 0) return '0;
        if (w_enable && addres_rd == a) return data_rd;
        return ma[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        return mb[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) chk("rd_a", da[k*32 +: 32], exp_a(ra[k*5 +: 5]));
        for (int k = 0; k < 2; k++) chk("rd_b", db[k*32 +: 32], exp_b(rb[k*5 +: 5]));
        chk("valid_a", {31'd0, va}, {31'd0, m_send});
        chk("valid_b", {31'd0, vb}, {31'd0, m_send});
        chk("busy_a", {31'd0, ba}, {31'd0, m_send | m_done});
        chk("busy_b", {31'd0, bb}, {31'd0, m_send | m_done});
        chk("done_a", {31'd0, dna}, {31'd0, m_done});
        chk("done_b", {31'd0, dnb}, {31'd0, m_done});
        if (m_send) begin
            chk("addr_a", {27'd0, aa}, 32'(m_idx));
            chk("addr_b", {27'd0, ab}, 32'(m_idx));
            chk("ddata_a", dda, exp_a(m_idx[4:0]));
            chk("ddata_b", ddb, exp_b(m_idx[4:0]));
        end
        if (!rst && va && dump_ready) begin
            log_addr.push_back(int'(aa));
            log_data.push_back(dda);
        end
        if (!rst && dna) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_rd_a0", da[31:0], 32'h0);
        chk("reset_rd_b1", db[63:32], 32'h0);
        chk("reset_dump_addr", {27'd0, aa}, 32'h0);
        chk("reset_dump_valid", {31'd0, va}, 32'h0);

        // Write-back of r3 and r1.
        w_enable = 1'b1; addres_rd = 5'd3; data_rd = 32'hFF010000;
        tick();
        addres_rd = 5'd1; data_rd = 32'hFF010011;
        tick();
        w_enable = 1'b0;
        rb = {5'd1, 5'd3};
        ra = {5'd31, 5'd2, 5'd1, 5'd3};
        #1;
        chk("wb_b_port0", db[31:0], 32'hFF010000);
        chk("wb_b_port1", db[63:32], 32'hFF010011);
        chk("wb_a_port0", da[31:0], 32'hFF010000);
        chk("wb_a_port1", da[63:32], 32'hFF010011);
        rst = 1'b1;
        #1;
        chk("rst_clear_b0", db[31:0], 32'h0);
        chk("rst_clear_b1", db[63:32], 32'h0);
        tick();
        rst = 1'b0;

        // Zero register.
        w_enable = 1'b1; addres_rd = 5'd0; data_rd = 32'hDEADBEEF;
        ra = '0; rb = '0;
        #1;
        chk("zero_a_during_write", da[31:0], 32'h0);
        chk("zero_b_during_write", db[31:0], 32'h0);
        tick();
        w_enable = 1'b0;
        #1;
        chk("zero_a_after", da[31:0], 32'h0);
        chk("zero_b_after", db[31:0], 32'hDEADBEEF);

        // Bypass of r7.
        w_enable = 1'b1; addres_rd = 5'd7; data_rd = 32'h12345678;
        ra = {4{5'd7}}; rb = {2{5'd7}};
        #1;
        chk("bypass_a0", da[31:0], 32'h12345678);
        chk("bypass_a1", da[63:32], 32'h12345678);
        chk("nobypass_b0", db[31:0], 32'h0);
        chk("nobypass_b1", db[63:32], 32'h0);
        tick();
        w_enable = 1'b0;
        #1;
        chk("nobypass_b_after", db[31:0], 32'h12345678);

        // Dump with ready every other cycle.
        for (int i = 0; i < 32; i++) begin
            w_enable = 1'b1; addres_rd = 5'(i); data_rd = 32'(i * 32'h11);
            tick();
        end
        w_enable = 1'b0;
        log_addr.delete(); log_data.delete(); done_cnt = 0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 70; i++) begin
            dump_ready = (i % 2 == 1);
            tick();
        end
        dump_ready = 1'b0;
        chk("dump_beats", 32'(log_addr.size()), 32'd32);
        for (int i = 0; i < 32 && i < log_addr.size(); i++) begin
            chk("dump_beat_addr", 32'(log_addr[i]), 32'(i));
            chk("dump_beat_data", log_data[i], 32'(i * 32'h11));
        end
        chk("dump_done_once", 32'(done_cnt), 32'd1);

        // Write during a stalled dump, plus an ignored second start.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0; dump_ready = 1'b1;
        repeat (5) tick();
        dump_ready = 1'b0;
        #1;
        chk("stall_addr5", {27'd0, aa}, 32'd5);
        w_enable = 1'b1; addres_rd = 5'd5; data_rd = 32'hA5A5A5A5; dump_start = 1'b1;
        #1;
        chk("live_a", dda, 32'hA5A5A5A5);
        chk("old_b", ddb, 32'h55);
        tick();
        w_enable = 1'b0; dump_start = 1'b0;
        #1;
        chk("after_edge_b", ddb, 32'hA5A5A5A5);
        chk("still_addr5", {27'd0, aa}, 32'd5);
        dump_ready = 1'b1;
        repeat (40) tick();
        dump_ready = 1'b0;
        chk("dump_done_twice", 32'(done_cnt), 32'd2);

        // Reset mid-dump and four concurrent reads.
        w_enable = 1'b1; addres_rd = 5'd1; data_rd = 32'h11111111;
        tick();
        addres_rd = 5'd2; data_rd = 32'h22222222;
        tick();
        addres_rd = 5'd31; data_rd = 32'h31313131;
        tick();
        w_enable = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0; dump_ready = 1'b1;
        repeat (10) tick();
        dump_ready = 1'b0;
        ra = {5'd31, 5'd1, 5'd2, 5'd1};
        #1;
        chk("mid_addr10", {27'd0, aa}, 32'd10);
        chk("quad_p0", da[31:0], 32'h11111111);
        chk("quad_p1", da[63:32], 32'h22222222);
        chk("quad_p2", da[95:64], 32'h11111111);
        chk("quad_p3", da[127:96], 32'h31313131);
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, va}, 32'h0);
        chk("abort_busy", {31'd0, ba}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'd2);

        // Randomized traffic checked by the per-cycle compare.
        for (int n = 0; n < 3000; n++) begin
            w_enable   = 1'($urandom);
            addres_rd  = 5'($urandom);
            data_rd    = $urandom;
            ra         = 20'($urandom);
            rb         = 10'($urandom);
            dump_start = ($urandom % 16 == 0);
            dump_ready = 1'($urandom);
            rst        = ($urandom % 400 == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
